note_scheduler: RTL
===================

# note_scheduler

Sequences song playback for the game datapath. It tracks the difficulty selected while the game is in DIFF mode and generates beat ticks at a difficulty-dependent period while the game is in RUN. On each beat it fetches the next note from the song ROM, counts notes, and raises a done pulse after the last note. It sits between the mode state machine (consumes `mode`, feeds `song_done` back as its finish request) and the note/lane display logic.

## Interface
- `BEAT_W`, 24: width of the beat prescale counter.
- `BEAT_EASY`, 12_000_000: beat period in clocks, difficulty 0.
- `BEAT_MED`, 8_000_000: beat period in clocks, difficulty 1.
- `BEAT_HARD`, 4_000_000: beat period in clocks, difficulty 2.
- `NUM_NOTES`, 41: notes per song, legal range 1..63.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, asynchronous, active-high.
- `mode` in 3: game mode. IDLE=1, EDIT=2, DIFF=3, RUN=4, PAUSE=5, FINISH=6. Other codes are treated as IDLE.
- `diff_btn` in 1: difficulty button, synchronous level.
- `note_data` in 4: song ROM lane bits, combinational read at `note_addr`.
- `note_addr` out 6: ROM address of the next note.
- `note_valid` out 1: one-cycle pulse when a note is issued.
- `note_lanes` out 4: lane bits of the last issued note.
- `note_count` out 6: number of notes issued this song.
- `difficulty` out 2: 0 easy, 1 medium, 2 hard.
- `beat` out 1: one-cycle beat tick.
- `song_done` out 1: one-cycle pulse when the last note is issued.

## Operation
- Reset: all outputs 0, difficulty 0, beat counter 0, state READY.
- Difficulty control:
  - `diff_btn` is registered internally. A rise is detected when the registered value is 1 and the previous registered value is 0.
  - In DIFF mode, each rise steps difficulty 0→1→2→0.
  - Rises in any other mode are ignored. A held button counts once.
- Period selection: `difficulty` selects BEAT_EASY/MED/HARD. Code 3 is unreachable; if it occurs, use BEAT_EASY.
- State machine states: READY, PLAYING, PAUSED, DONE.
  - READY→PLAYING when mode==RUN.
  - PLAYING→PAUSED when mode==PAUSE.
  - PAUSED→PLAYING when mode==RUN.
  - PLAYING or PAUSED→READY when mode is anything else.
  - PLAYING→DONE on the beat that issues note NUM_NOTES.
  - DONE holds while mode is RUN or PAUSE; otherwise →READY.
- Entering READY clears the beat counter, `note_addr`, `note_count` and `note_lanes`. Difficulty is kept.
- Beat counter behaviour:
  - Counts only in PLAYING with mode==RUN.
  - `beat` = PLAYING && mode==RUN && counter >= period-1.
  - On beat the counter returns to 0; otherwise it increments.
  - PAUSED and DONE hold the counter.
- Note issue, on the clock edge ending a beat cycle:
  - `note_lanes` <= `note_data`; `note_valid` <= 1.
  - `note_addr` <= +1; `note_count` <= +1.
  - If the new count == NUM_NOTES: `song_done` <= 1 and state → DONE.
- `note_valid` and `song_done` are 0 in every other cycle. Nothing is issued in DONE.

## Timing
- `beat` is combinational from registered state and `mode`. All other outputs are registered.
- First beat occurs on the period-th PLAYING cycle; `note_valid` follows 1 cycle later.
- Total latency from the first RUN cycle (state READY) to the first `note_valid` = period+1 cycles. Subsequent notes arrive every period cycles.
- Pause stretches the interval between notes by exactly the number of PAUSE cycles; the counter phase is preserved.
- If mode leaves RUN in a cycle where the counter is at period-1, `beat` is suppressed and no note is issued.
- `difficulty` updates 2 cycles after the `diff_btn` rise: 1 cycle for the input register, 1 for the update.
- `rst` asserted mid-song immediately forces the reset values.
- `note_addr` never exceeds NUM_NOTES.

## Test plan
Benches use overrides BEAT_EASY=8, BEAT_MED=6, BEAT_HARD=4, NUM_NOTES=3, with `note_data` = `note_addr[3:0]` + 1.
- Reset: assert `rst` mid-operation → all outputs 0 and difficulty 0 in the same cycle.
- Difficulty: mode=DIFF, 4 separate button rises → difficulty 1, 2, 0, 1. One 5-cycle hold → single step. Rise with mode=EDIT → no change.
- Hard playback: difficulty 2, mode=RUN at cycle 0 → `note_valid` at cycles 5, 9, 13 with `note_lanes` 1, 2, 3. `song_done` at cycle 13. No further pulses; `note_count` holds 3.
- Pause: easy difficulty, mode=PAUSE for 10 cycles starting 3 cycles after the first note → second note arrives 18 cycles after the first (8+10).
- Abort and restart: mode=IDLE after the 2nd note → `note_addr` and `note_count` 0 next cycle. Return to RUN → notes restart at lane value 1 after 5 cycles (hard difficulty).
- Boundary: mode switches to PAUSE in the cycle where the counter is 3 (hard) → no `beat` and no `note_valid`. On resume, the note issues on the first RUN cycle and `note_valid` follows on the next cycle.

Source files
------------

// File: rtl/note_scheduler.sv
// Song playback sequencer: tracks difficulty in DIFF mode, generates beat ticks in RUN,
// fetches one note per beat from the song ROM and pulses song_done after the last note.
module note_scheduler #(
  parameter int BEAT_W    = 24,
  parameter int BEAT_EASY = 12_000_000,
  parameter int BEAT_MED  = 8_000_000,
  parameter int BEAT_HARD = 4_000_000,
  parameter int NUM_NOTES = 41
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode,
  input  logic       diff_btn,
  input  logic [3:0] note_data,
  output logic [5:0] note_addr,
  output logic       note_valid,
  output logic [3:0] note_lanes,
  output logic [5:0] note_count,
  output logic [1:0] difficulty,
  output logic       beat,
  output logic       song_done
);

  typedef enum logic [1:0] {READY, PLAYING, PAUSED, DONE} state_t;

  localparam logic [2:0] MODE_DIFF  = 3'd3;
  localparam logic [2:0] MODE_RUN   = 3'd4;
  localparam logic [2:0] MODE_PAUSE = 3'd5;

  localparam logic [BEAT_W-1:0] LAST_EASY = BEAT_W'(BEAT_EASY - 1);
  localparam logic [BEAT_W-1:0] LAST_MED  = BEAT_W'(BEAT_MED - 1);
  localparam logic [BEAT_W-1:0] LAST_HARD = BEAT_W'(BEAT_HARD - 1);
  localparam logic [5:0]        LAST_NOTE = 6'(NUM_NOTES);

  state_t            state_q, state_d;
  logic              btn_q, btn_prev;
  logic [BEAT_W-1:0] cnt_q;
  logic [BEAT_W-1:0] period_m1;
  logic              is_run, is_pause, active, issue_last;

  assign is_run   = (mode == MODE_RUN);
  assign is_pause = (mode == MODE_PAUSE);

  always_comb begin
    period_m1 = LAST_EASY;
    case (difficulty)
      2'd1:    period_m1 = LAST_MED;
      2'd2:    period_m1 = LAST_HARD;
      default: period_m1 = LAST_EASY;
    endcase
  end

  // The resume cycle (PAUSED with mode==RUN) already counts as playing, so a pause
  // stretches the note interval by exactly its length and a beat held off by the
  // pause fires on the first RUN cycle.
  assign active     = ((state_q == PLAYING) || (state_q == PAUSED)) && is_run;
  assign beat       = active && (cnt_q >= period_m1);
  assign issue_last = beat && ((note_count + 6'd1) == LAST_NOTE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      READY:   if (is_run) state_d = PLAYING;
      PLAYING,
      PAUSED: begin
        if (issue_last)    state_d = DONE;
        else if (is_run)   state_d = PLAYING;
        else if (is_pause) state_d = PAUSED;
        else               state_d = READY;
      end
      DONE:    if (!(is_run || is_pause)) state_d = READY;
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= READY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q      <= 1'b0;
      btn_prev   <= 1'b0;
      difficulty <= '0;
      cnt_q      <= '0;
      note_addr  <= '0;
      note_count <= '0;
      note_lanes <= '0;
      note_valid <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      btn_q    <= diff_btn;
      btn_prev <= btn_q;
      if (btn_q && !btn_prev && (mode == MODE_DIFF))
        difficulty <= (difficulty >= 2'd2) ? 2'd0 : difficulty + 2'd1;

      note_valid <= beat;
      song_done  <= issue_last;

      if (state_d == READY) begin
        cnt_q      <= '0;
        note_addr  <= '0;
        note_count <= '0;
        note_lanes <= '0;
      end else if (beat) begin
        cnt_q      <= '0;
        note_lanes <= note_data;
        note_addr  <= note_addr + 6'd1;
        note_count <= note_count + 6'd1;
      end else if (active) begin
        cnt_q <= cnt_q + BEAT_W'(1);
      end
    end
  end

endmodule
